// File: rtl/mips_seq_divider.sv
// mips_seq_divider
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU. The quotient feeds LO
// and the remainder feeds HI. One iteration per clock, WIDTH iterations per
// division. Results appear WIDTH+1 edges after the accepted start.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   start        division request, honoured only while ready=1
//   is_signed    1 = DIV (two's complement), 0 = DIVU
//   dividend     rs operand, captured on an accepted start
//   divisor      rt operand, captured on an accepted start
//   ready        high in IDLE or DONE
//   busy         high while iterating
//   done         one-cycle pulse; results are valid from this cycle on
//   quotient     LO value, held until the next result
//   remainder    HI value, held until the next result
//   div_by_zero  set with done when the captured divisor was zero
module mips_seq_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] pr;        // partial remainder
    logic [WIDTH-1:0] qsr;       // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] dvd_raw;
    logic             sgn_op;
    logic             dvd_neg;
    logic             dvs_neg;
    logic             dvs_zero;

    logic                    accept;
    logic                    last_iter;
    logic        [WIDTH:0]   pr_sh;
    logic signed [WIDTH:0]   trial;
    logic                    trial_neg;
    logic        [WIDTH-1:0] q_step;
    logic        [WIDTH-1:0] r_step;

    function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] v);
        return (~v) + ONE;
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             sgn);
        return (sgn && v[WIDTH-1]) ? neg2c(v) : v;
    endfunction

    assign accept    = start && ready;
    assign last_iter = (state == RUN) && (cnt == CNT_LAST);

    // The invariant pr < dvs_mag keeps pr_sh below 2*dvs_mag, so bit WIDTH of
    // the WIDTH+1-bit difference is an exact sign of the trial subtraction.
    assign pr_sh     = {pr, qsr[WIDTH-1]};
    assign trial     = $signed(pr_sh) - $signed({1'b0, dvs_mag});
    assign trial_neg = trial[WIDTH];
    assign q_step    = {qsr[WIDTH-2:0], ~trial_neg};
    assign r_step    = trial_neg ? pr_sh[WIDTH-1:0] : trial[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == CNT_LAST) state_nxt = DONE;
            end
            DONE: begin
                ready     = 1'b1;
                done      = 1'b1;
                state_nxt = start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            pr          <= '0;
            qsr         <= '0;
            dvs_mag     <= '0;
            dvd_raw     <= '0;
            sgn_op      <= 1'b0;
            dvd_neg     <= 1'b0;
            dvs_neg     <= 1'b0;
            dvs_zero    <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            sgn_op   <= is_signed;
            dvd_neg  <= dividend[WIDTH-1];
            dvs_neg  <= divisor[WIDTH-1];
            dvs_zero <= (divisor == '0);
            dvd_raw  <= dividend;
            dvs_mag  <= magnitude(divisor, is_signed);
            qsr      <= magnitude(dividend, is_signed);
            pr       <= '0;
            cnt      <= '0;
        end else if (state == RUN) begin
            pr  <= r_step;
            qsr <= q_step;
            cnt <= last_iter ? '0 : cnt + CNT_ONE;
            if (last_iter) begin
                if (dvs_zero) begin
                    quotient    <= '1;
                    remainder   <= dvd_raw;
                    div_by_zero <= 1'b1;
                end else begin
                    quotient    <= (sgn_op && (dvd_neg != dvs_neg)) ? neg2c(q_step) : q_step;
                    remainder   <= (sgn_op && dvd_neg) ? neg2c(r_step) : r_step;
                    div_by_zero <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_seq_divider.sv
module tb_mips_seq_divider;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        ready, busy, done;
    logic [31:0] quotient, remainder;
    logic        div_by_zero;

    int   checks = 0;
    int   errors = 0;
    res_t sb[$];

    mips_seq_divider #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .ready(ready), .busy(busy),
        .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference: plain integer division; truncation toward zero and a
    // remainder carrying the dividend's sign are native to SV / and %.
    function automatic res_t ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        res_t   res;
        longint sa, sb_;
        if (b == 32'd0) begin
            res.q = 32'hFFFF_FFFF;
            res.r = a;
            res.z = 1'b1;
        end else if (s) begin
            sa  = longint'($signed(a));
            sb_ = longint'($signed(b));
            res.q = 32'(sa / sb_);
            res.r = 32'(sa % sb_);
            res.z = 1'b0;
        end else begin
            res.q = a / b;
            res.r = a % b;
            res.z = 1'b0;
        end
        return res;
    endfunction

    // Monitor: tracks the cycle position t of the current division
    // (0 idle, 1..32 iterating, 33 done) and checks handshake and results.
    initial begin : monitor
        int   t;
        res_t held, exp_r, got;
        logic e_ready, e_busy, e_done;
        t    = 0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                t    = 0;
                held = '0;
                sb.delete();
            end else begin
                e_ready = (t == 0) || (t == 33);
                e_busy  = (t >= 1) && (t <= 32);
                e_done  = (t == 33);
                got     = '{quotient, remainder, div_by_zero};
                checks++;
                if ({ready, busy, done} !== {e_ready, e_busy, e_done}) begin
                    errors++;
                    $display("FAIL handshake t=%0d got ready/busy/done=%b%b%b want %b%b%b",
                             t, ready, busy, done, e_ready, e_busy, e_done);
                end
                if (e_done) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL result: done with empty scoreboard, got q=%h r=%h z=%b",
                                 quotient, remainder, div_by_zero);
                    end else begin
                        exp_r = sb.pop_front();
                        if (got !== exp_r) begin
                            errors++;
                            $display("FAIL result got q=%h r=%h z=%b want q=%h r=%h z=%b",
                                     got.q, got.r, got.z, exp_r.q, exp_r.r, exp_r.z);
                        end
                        held = exp_r;
                    end
                end else begin
                    checks++;
                    if (got !== held) begin
                        errors++;
                        $display("FAIL hold t=%0d got q=%h r=%h z=%b want q=%h r=%h z=%b",
                                 t, got.q, got.r, got.z, held.q, held.r, held.z);
                    end
                end
                if (start && e_ready) begin
                    sb.push_back(ref_div(is_signed, dividend, divisor));
                    t = 1;
                end else if (t == 33) begin
                    t = 0;
                end else if (t > 0) begin
                    t++;
                end
            end
        end
    end

    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        while (!ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready) begin
            errors++;
            $display("FAIL ready_timeout got ready=%b want 1", ready);
        end
        is_signed = s;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = 1'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || !ready) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending results want 0", sb.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({ready, busy, done, quotient, remainder, div_by_zero} !== {3'b100, 65'd0}) begin
            errors++;
            $display("FAIL %s got ready=%b busy=%b done=%b q=%h r=%h z=%b want 1 0 0 0 0 0",
                     tag, ready, busy, done, quotient, remainder, div_by_zero);
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [31:0] b;
        #1 rst = 1'b1;
        #1 check_reset_outputs("reset_async");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_div(1'b0, 32'd100, 32'd7);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2);
        run_div(1'b0, 32'hFFFF_FFF9, 32'd2);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE);
        run_div(1'b0, 32'h1234_5678, 32'd0);
        run_div(1'b1, 32'hFFFF_FFFB, 32'd0);
        run_div(1'b0, 32'd5, 32'd9);
        drain();

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       b = $urandom;
                1:       b = $urandom_range(1, 15);
                2:       b = -$urandom_range(1, 15);
                default: b = $urandom_range(0, 255);
            endcase
            run_div(1'($urandom), $urandom, b);
        end
        drain();

        // Start held high: accepted only in DONE cycles, ignored while busy.
        start = 1'b1;
        for (int i = 0; i < 150; i++) begin
            is_signed = 1'(i & 1);
            dividend  = $urandom;
            divisor   = $urandom_range(0, 3) == 0 ? -$urandom_range(1, 9) : $urandom_range(1, 1000);
            @(posedge clk); #1;
        end
        start = 1'b0;
        drain();

        // Asynchronous reset in the middle of a division.
        run_div(1'b0, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        #1 check_reset_outputs("reset_mid_run");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_div(1'b0, 32'd9, 32'd3);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
